// File: rtl/ula_pkg.sv
// Shared types and constants for the nibble-serial ALU.
//   state_t : sequencer states (IDLE accepts, RUN steps one nibble per clock,
//             DONE holds the result until the consumer takes it)
//   OP_ADD  : 74181 select code for A plus B (arithmetic mode)
//   OP_SUB  : 74181 select code for A minus B minus 1 (plus carry-in)
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // Signed overflow of the full-width result. Only add and subtract in
  // arithmetic mode have a meaningful two's-complement overflow.
  function automatic logic signed_ovf(input logic [3:0] s, input logic m,
                                      input logic a_msb, input logic b_msb,
                                      input logic f_msb);
    logic ovf;
    ovf = 1'b0;
    if (!m) begin
      if (s == OP_ADD) ovf = (a_msb == b_msb) && (f_msb != a_msb);
      else if (s == OP_SUB) ovf = (a_msb != b_msb) && (f_msb == b_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/ula_74181.sv
// One 4-bit 74181 ALU slice, purely combinational, active-high data and
// active-high carry (c_in=1 means "carry in", c_out=1 means "carry out").
// Ports:
//   a, b    : 4-bit operands
//   s       : function select
//   m       : 1 = logic mode, 0 = arithmetic mode
//   c_in    : carry into bit 0
//   f       : 4-bit result
//   c_out   : carry out of bit 3
//   a_eq_b  : all result bits set (A==B when doing A minus B minus 1)
//   p, g    : slice group propagate / generate (active high)
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b,
  output logic       p,
  output logic       g
);

  // The chip's arithmetic is x + y + c_in: s[1:0] picks x from
  // {A, A|B, A|~B, 1111}, s[3:2] picks y from {0, A&~B, A&B, A}.
  // y is always a subset of x, so x is the per-bit propagate and y the
  // per-bit generate. Logic mode is the carry-free sum, inverted.
  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] c;

  assign x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

  always_comb begin
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = y[i] | (x[i] & c[i]);
    end
  end

  assign f      = m ? ~(x ^ y) : (x ^ y ^ c[3:0]);
  assign p      = &x;
  assign g      = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);
  assign c_out  = g | (p & c_in);
  assign a_eq_b = &f;

endmodule

// File: rtl/ula_nibble_serial.sv
// WIDTH-bit ALU that reuses one ula_74181 slice over WIDTH/4 clocks,
// LSB nibble first, rippling the carry through a register. Results and
// flags match a combinational cascade of WIDTH/4 slices.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake; a, b, s, m, c_in are
//                           captured on the cycle both are high
//   out_valid / out_ready : result handshake; result held while
//                           out_valid && !out_ready
//   f, c_out, overflow,
//   a_eq_b, p, g          : result and flags, qualified by out_valid
//   dbg_state             : current sequencer state
// Handshake rule: a transfer happens on a rising edge where valid and
// ready are both high; valid is never withdrawn by this block before the
// transfer, and ready does not depend on valid.
module ula_nibble_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             overflow,
  output logic             a_eq_b,
  output logic             p,
  output logic             g,
  output state_t           dbg_state
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = $clog2(NSLICE) + 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("ula_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   idx;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [3:0]      s_l;
  logic            m_l;
  logic            carry;
  logic            eq_acc;
  logic            p_acc;
  logic            g_acc;
  logic            last;

  logic [3:0]      sl_f;
  logic            sl_c;
  logic            sl_eq;
  logic            sl_p;
  logic            sl_g;

  assign last = (idx == CW'(NSLICE - 1));

  ula_74181 u_slice (
    .a      (a_l[4*idx +: 4]),
    .b      (b_l[4*idx +: 4]),
    .s      (s_l),
    .m      (m_l),
    .c_in   (carry),
    .f      (sl_f),
    .c_out  (sl_c),
    .a_eq_b (sl_eq),
    .p      (sl_p),
    .g      (sl_g)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  // Datapath: operand capture, per-nibble result write, flag accumulation.
  // f and the flags are only rewritten during RUN, so they keep the last
  // result through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_l      <= '0;
      b_l      <= '0;
      s_l      <= '0;
      m_l      <= 1'b0;
      carry    <= 1'b0;
      eq_acc   <= 1'b0;
      p_acc    <= 1'b0;
      g_acc    <= 1'b0;
      f        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      a_eq_b   <= 1'b0;
      p        <= 1'b0;
      g        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_l    <= a;
            b_l    <= b;
            s_l    <= s;
            m_l    <= m;
            idx    <= '0;
            carry  <= c_in;
            eq_acc <= 1'b1;
            p_acc  <= 1'b1;
            g_acc  <= 1'b0;
          end
        end
        RUN: begin
          f[4*idx +: 4] <= sl_f;
          carry         <= sl_c;
          eq_acc        <= eq_acc & sl_eq;
          p_acc         <= p_acc & sl_p;
          g_acc         <= sl_g | (sl_p & g_acc);
          // Wrap to 0 on the last nibble so the slice never sees an
          // out-of-range part-select while idle.
          idx           <= last ? '0 : idx + CW'(1);
          if (last) begin
            c_out    <= sl_c;
            // The top nibble's f[3] is the final result's sign bit.
            overflow <= signed_ovf(s_l, m_l, a_l[WIDTH-1], b_l[WIDTH-1], sl_f[3]);
            a_eq_b   <= eq_acc & sl_eq;
            p        <= p_acc & sl_p;
            g        <= sl_g | (sl_p & g_acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nibble_serial.sv
module tb_ula_nibble_serial;
  import ula_pkg::*;

  parameter int W = 16;
  localparam int NSLICE = W / 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   s;
  logic         m;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         c_out;
  logic         overflow;
  logic         a_eq_b;
  logic         p;
  logic         g;
  state_t       dbg_state;

  ula_nibble_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .c_out     (c_out),
    .overflow  (overflow),
    .a_eq_b    (a_eq_b),
    .p         (p),
    .g         (g),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Expected entry layout: {f, c_out, overflow, a_eq_b, p, g}
  logic [W+4:0] exp_q[$];
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model taken from the 74181 function table (active-high data).
  // Arithmetic entries are written as "t1 plus t2 plus carry"; minus forms
  // use the two's-complement operand. Group generate is the carry out with
  // no carry in; group propagate means no bit position kills a carry.
  function automatic logic [W+4:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                         input logic [3:0] si, input logic mi, input logic ci);
    logic [W:0] ae, be, nb, ones, t1, t2, sum_c, sum_0;
    logic [W-1:0] fl, fr;
    logic ovf;
    ae   = {1'b0, ai};
    be   = {1'b0, bi};
    nb   = {1'b0, ~bi};
    ones = {1'b0, {W{1'b1}}};
    t1 = '0;
    t2 = '0;
    case (si)
      4'h0: begin t1 = ae;        t2 = '0;        end // A
      4'h1: begin t1 = ae | be;   t2 = '0;        end // A or B
      4'h2: begin t1 = ae | nb;   t2 = '0;        end // A or ~B
      4'h3: begin t1 = ones;      t2 = '0;        end // minus 1
      4'h4: begin t1 = ae;        t2 = ae & nb;   end // A plus A&~B
      4'h5: begin t1 = ae | be;   t2 = ae & nb;   end // (A|B) plus A&~B
      4'h6: begin t1 = ae;        t2 = nb;        end // A minus B minus 1
      4'h7: begin t1 = ae & nb;   t2 = ones;      end // A&~B minus 1
      4'h8: begin t1 = ae;        t2 = ae & be;   end // A plus A&B
      4'h9: begin t1 = ae;        t2 = be;        end // A plus B
      4'hA: begin t1 = ae | nb;   t2 = ae & be;   end // (A|~B) plus A&B
      4'hB: begin t1 = ae & be;   t2 = ones;      end // A&B minus 1
      4'hC: begin t1 = ae;        t2 = ae;        end // A plus A
      4'hD: begin t1 = ae | be;   t2 = ae;        end // (A|B) plus A
      4'hE: begin t1 = ae | nb;   t2 = ae;        end // (A|~B) plus A
      default: begin t1 = ae;     t2 = ones;      end // A minus 1
    endcase
    sum_c = t1 + t2 + {{W{1'b0}}, ci};
    sum_0 = t1 + t2;
    case (si)
      4'h0: fl = ~ai;
      4'h1: fl = ~(ai | bi);
      4'h2: fl = ~ai & bi;
      4'h3: fl = '0;
      4'h4: fl = ~(ai & bi);
      4'h5: fl = ~bi;
      4'h6: fl = ai ^ bi;
      4'h7: fl = ai & ~bi;
      4'h8: fl = ~ai | bi;
      4'h9: fl = ~(ai ^ bi);
      4'hA: fl = bi;
      4'hB: fl = ai & bi;
      4'hC: fl = '1;
      4'hD: fl = ai | ~bi;
      4'hE: fl = ai | bi;
      default: fl = ai;
    endcase
    fr  = mi ? fl : sum_c[W-1:0];
    ovf = !mi && (((si == 4'b1001) && (ai[W-1] == bi[W-1]) && (fr[W-1] != ai[W-1])) ||
                  ((si == 4'b0110) && (ai[W-1] != bi[W-1]) && (fr[W-1] == bi[W-1])));
    return {fr, sum_c[W], ovf, &fr, &(t1[W-1:0] | t2[W-1:0]), sum_0[W]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge. Returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [3:0] si, input logic mi, input logic ci);
    int waited;
    waited = 0;
    while (!in_ready && waited < 32) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    a = ai; b = bi; s = si; m = mi; c_in = ci;
    in_valid = 1'b1;
    exp_q.push_back(model(ai, bi, si, mi, ci));
    @(posedge clk); #1;
    // Inputs must be ignored once the operation is running.
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic finish_op(input int hold);
    int cycles;
    logic [W+4:0] e;
    cycles = 0;
    while (!out_valid && cycles < 64) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", cycles, NSLICE);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_f", f, e[W+4:5]);
      check("hold_flags", {c_out, overflow, a_eq_b, p, g}, e[4:0]);
    end
    in_valid = 1'b0;
    check("f", f, e[W+4:5]);
    check("c_out", c_out, e[4]);
    check("overflow", overflow, e[3]);
    check("a_eq_b", a_eq_b, e[2]);
    check("p", p, e[1]);
    check("g", g, e[0]);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_in_ready", in_ready, 1);
    check("ret_out_valid", out_valid, 0);
  endtask

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [3:0] si, input logic mi, input logic ci, input int hold);
    start_op(ai, bi, si, mi, ci);
    finish_op(hold);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_f"}, f, 0);
    check({tag, "_flags"}, {c_out, overflow, a_eq_b, p, g}, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    if (W == 16) begin
      // Directed: add, including exact-value checks alongside the model.
      run_op(16'h000F, 16'h0001, OP_ADD, 1'b0, 1'b0, 0);
      check("add1_f_const", f, 16'h0010);
      run_op(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 0);
      check("add2_f_const", f, 16'h8000);
      check("add2_ovf_const", overflow, 1);
      run_op(16'h8000, 16'h8000, OP_ADD, 1'b0, 1'b0, 0);
      check("add3_cout_const", c_out, 1);
      check("add3_ovf_const", overflow, 1);
      // Subtract across the sign boundary, both carry-ins.
      run_op(16'h8000, 16'h0001, OP_SUB, 1'b0, 1'b0, 0);
      check("sub0_ovf_const", overflow, 1);
      run_op(16'h8000, 16'h0001, OP_SUB, 1'b0, 1'b1, 0);
      check("sub1_f_const", f, 16'h7FFF);
      // Equality compare: A minus B minus 1 with A==B gives all ones.
      run_op(16'h1234, 16'h1234, OP_SUB, 1'b0, 1'b0, 0);
      check("eq_const", a_eq_b, 1);
      // Logic XOR
      run_op(16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b0, 0);
      check("xor_f_const", f, 16'hFFFF);
    end

    // Every select code in both modes with both carry-ins.
    for (int si = 0; si < 16; si++)
      for (int mi = 0; mi < 2; mi++)
        for (int ci = 0; ci < 2; ci++)
          run_op(W'($urandom), W'($urandom), 4'(si), 1'(mi), 1'(ci), 0);

    // Consumer stalls in DONE for 5 cycles while in_valid is toggled.
    run_op(W'($urandom), W'($urandom), OP_ADD, 1'b0, 1'b1, 5);

    // Reset in the middle of RUN: result dropped, no out_valid.
    start_op(W'($urandom), W'($urandom), OP_ADD, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_reset_state("abort");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_valid", out_valid, 0);
    run_op(16'h00FF & W'(16'hFFFF), W'(1), OP_ADD, 1'b0, 1'b0, 0);

    // Randomized operations with random consumer stalls.
    for (int k = 0; k < 300; k++)
      run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2));

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
